// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU results with a 2-deep load-return FIFO,
// forces the load head through after STARVE_LIM lost arbitrations and tracks pending-load hazards.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_rd,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    input  logic [ADDR_W-1:0] q_rd,
    output logic              stall_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              proto_err
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fifo_rd   [2];
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_cnt;
    logic              fifo_empty, fifo_full, push, pop, wr_idx;
    logic [CNT_W-1:0]  starve_cnt, starve_next;
    logic [NREG-1:0]   busy, busy_next;
    logic              grant_vld_p0, perr_set;
    logic [ADDR_W-1:0] grant_rd_p0;
    logic [DATA_W-1:0] grant_data_p0;
    logic              hazard;

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign fifo_full  = (fifo_cnt == 2'd2);
    assign ld_ready   = rst_n & ~fifo_full;
    assign push       = ld_valid & ld_ready;
    // A pop at occupancy 1 frees slot 0 for the incoming entry.
    assign wr_idx     = (fifo_cnt == 2'd1) & ~pop;

    always_comb begin
        state_next    = state;
        grant_vld_p0  = 1'b0;
        grant_rd_p0   = '0;
        grant_data_p0 = '0;
        pop           = 1'b0;
        perr_set      = 1'b0;
        starve_next   = '0;
        case (state)
            NORMAL: begin
                if (alu_valid) begin
                    grant_vld_p0  = 1'b1;
                    grant_rd_p0   = alu_rd;
                    grant_data_p0 = alu_data;
                    if (!fifo_empty) begin
                        starve_next = starve_cnt + CNT_W'(1);
                        if (starve_next >= CNT_W'(STARVE_LIM))
                            state_next = FORCE;
                    end
                end else if (!fifo_empty) begin
                    grant_vld_p0  = 1'b1;
                    grant_rd_p0   = fifo_rd[0];
                    grant_data_p0 = fifo_data[0];
                    pop           = 1'b1;
                end
            end
            FORCE: begin
                // ALU traffic is dropped here; the head is always present on entry.
                perr_set   = alu_valid;
                state_next = NORMAL;
                if (!fifo_empty) begin
                    grant_vld_p0  = 1'b1;
                    grant_rd_p0   = fifo_rd[0];
                    grant_data_p0 = fifo_data[0];
                    pop           = 1'b1;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    always_comb begin
        busy_next = busy;
        if (pop)
            busy_next[fifo_rd[0]] = 1'b0;
        if (ld_issue && ld_issue_rd != '0)
            busy_next[ld_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign hazard = (q_rs1 != '0 && busy[q_rs1]) |
                    (q_rs2 != '0 && busy[q_rs2]) |
                    (q_rd  != '0 && busy[q_rd]);
    assign stall_req = rst_n & (hazard | (state == FORCE) | (state_next == FORCE));

    // Stage p0 -> p1: granted request lands on the register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            proto_err  <= 1'b0;
            busy       <= '0;
            fifo_cnt   <= 2'd0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_rd[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            busy       <= busy_next;
            if (perr_set)
                proto_err <= 1'b1;
            wr_en   <= grant_vld_p0 & (grant_rd_p0 != '0);
            wr_addr <= grant_rd_p0;
            wr_data <= grant_data_p0;
            if (pop) begin
                fifo_rd[0]   <= fifo_rd[1];
                fifo_data[0] <= fifo_data[1];
            end
            if (push) begin
                fifo_rd[wr_idx]   <= ld_rd;
                fifo_data[wr_idx] <= ld_data;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// against a queue-based behavioural model of the writeback rules.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32, ADDR_W = 5, STARVE_LIM = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic alu_valid, ld_valid, ld_ready, ld_issue, stall_req, wr_en, proto_err;
    logic [ADDR_W-1:0] alu_rd, ld_rd, ld_issue_rd, q_rs1, q_rs2, q_rd, wr_addr;
    logic [DATA_W-1:0] alu_data, ld_data, wr_data;

    int tests = 0, fails = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .stall_req(stall_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: load FIFO as a queue, scoreboard as a bit array.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ld_t;

    ld_t               mq[$];
    bit                mbusy[32];
    int                mstarve;
    bit                mforce, mperr, me_wr, me_ready, me_stall, m_will_force;
    logic [ADDR_W-1:0] me_addr;
    logic [DATA_W-1:0] me_data;

    function automatic void model_reset();
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mstarve = 0; mforce = 0; mperr = 0; me_wr = 0; me_addr = '0; me_data = '0;
    endfunction

    function automatic void model_eval();
        me_ready     = rst_n && (mq.size() < 2);
        m_will_force = !mforce && alu_valid && (mq.size() > 0) && (mstarve + 1 >= STARVE_LIM);
        me_stall     = rst_n && ((q_rs1 != 0 && mbusy[q_rs1]) || (q_rs2 != 0 && mbusy[q_rs2]) ||
                                 (q_rd != 0 && mbusy[q_rd]) || m_will_force || mforce);
    endfunction

    function automatic void model_commit();
        ld_t head;
        bit  do_push;
        do_push = ld_valid && me_ready;
        me_wr   = 0;
        if (mforce || (!alu_valid && mq.size() > 0)) begin
            if (mforce && alu_valid) mperr = 1;
            if (mq.size() > 0) begin
                head = mq.pop_front();
                mbusy[head.rd] = 0;
                me_wr = (head.rd != 0); me_addr = head.rd; me_data = head.data;
            end
            mforce  = 0;
            mstarve = 0;
        end else if (alu_valid) begin
            me_wr = (alu_rd != 0); me_addr = alu_rd; me_data = alu_data;
            mstarve = (mq.size() > 0) ? mstarve + 1 : 0;
            mforce  = m_will_force;
        end else begin
            mstarve = 0;
        end
        if (do_push) mq.push_back('{rd: ld_rd, data: ld_data});
        if (ld_issue && ld_issue_rd != 0) mbusy[ld_issue_rd] = 1;
    endfunction

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_valid = 0; ld_rd = '0; ld_data = '0;
        ld_issue = 0; ld_issue_rd = '0;
        q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst_n) model_commit(); else model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        settle();
        tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall_req); end
        tests++; if ({wr_en, wr_addr, wr_data, proto_err} !== '0) begin fails++;
            $display("FAIL reset_outputs got en=%b addr=%0d data=%h perr=%b want all 0", wr_en, wr_addr, wr_data, proto_err); end
        tick();
        rst_n = 1;
        settle();
        tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ld_ready got %b want 1", ld_ready); end
        tick();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL post_reset_wr_en got %b want 0", wr_en); end
    endtask

    task automatic test_alu_only();
        idle(); alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_0005;
        tick();
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'h5}) begin fails++;
            $display("FAIL alu_only got en=%b addr=%0d data=%h want 1/3/5", wr_en, wr_addr, wr_data); end
        alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        tick();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL alu_x0 wr_en got %b want 0", wr_en); end
        idle();
        tick();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL alu_idle wr_en got %b want 0", wr_en); end
    endtask

    task automatic test_collision();
        idle(); ld_issue = 1; ld_issue_rd = 5'd5;
        tick();
        idle(); alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
        ld_valid = 1; ld_rd = 5'd5; ld_data = 32'h55; q_rs1 = 5'd5;
        settle();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL coll_busy5 stall got %b want 1", stall_req); end
        tick();
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd4, 32'h44}) begin fails++;
            $display("FAIL coll_alu got en=%b addr=%0d data=%h want 1/4/44", wr_en, wr_addr, wr_data); end
        idle(); q_rs1 = 5'd5;
        settle();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL coll_busy5_held stall got %b want 1", stall_req); end
        tick();
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'h55}) begin fails++;
            $display("FAIL coll_ld got en=%b addr=%0d data=%h want 1/5/55", wr_en, wr_addr, wr_data); end
        settle();
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL coll_busy5_clear stall got %b want 0", stall_req); end
    endtask

    task automatic test_scoreboard();
        idle(); ld_issue = 1; ld_issue_rd = 5'd0;
        tick();
        ld_issue_rd = 5'd7;
        tick();
        idle(); q_rs2 = 5'd0;
        settle();
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL sb_x0 stall got %b want 0", stall_req); end
        q_rd = 5'd7;
        settle();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL sb_rd7 stall got %b want 1", stall_req); end
        q_rd = 5'd0; q_rs1 = 5'd7;
        for (int i = 0; i < 2; i++) begin
            settle();
            tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL sb_wait%0d stall got %b want 1", i, stall_req); end
            tick();
        end
        ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        ld_valid = 0;
        settle();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL sb_queued stall got %b want 1", stall_req); end
        tick();
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h77}) begin fails++;
            $display("FAIL sb_write got en=%b addr=%0d data=%h want 1/7/77", wr_en, wr_addr, wr_data); end
        settle();
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL sb_released stall got %b want 0", stall_req); end
    endtask

    task automatic test_starvation();
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL starve_perr_init got %b want 0", proto_err); end
        idle(); alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
        ld_valid = 1; ld_rd = 5'd6; ld_data = 32'h66;
        tick();
        ld_valid = 0;
        for (int i = 1; i <= 3; i++) begin
            alu_rd = ADDR_W'(i + 1); alu_data = DATA_W'(i);
            settle();
            tests++; if (stall_req !== (i == 3)) begin fails++; $display("FAIL starve_stall%0d got %b want %b", i, stall_req, i == 3); end
            tick();
            tests++; if ({wr_en, wr_addr} !== {1'b1, ADDR_W'(i + 1)}) begin fails++;
                $display("FAIL starve_alu%0d got en=%b addr=%0d want 1/%0d", i, wr_en, wr_addr, i + 1); end
        end
        alu_rd = 5'd9; alu_data = 32'h99;
        settle();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL force_stall got %b want 1", stall_req); end
        tick();
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd6, 32'h66}) begin fails++;
            $display("FAIL force_write got en=%b addr=%0d data=%h want 1/6/66", wr_en, wr_addr, wr_data); end
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL force_perr got %b want 1", proto_err); end
        idle();
        settle();
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL force_exit_stall got %b want 0", stall_req); end
        tick();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL force_dropped wr_en got %b want 0", wr_en); end
    endtask

    task automatic test_fifo_full();
        logic [ADDR_W-1:0] exp_rd [3];
        logic [DATA_W-1:0] exp_dt [3];
        exp_rd[0] = 5'd8; exp_rd[1] = 5'd9; exp_rd[2] = 5'd10;
        exp_dt[0] = 32'h88; exp_dt[1] = 32'h99; exp_dt[2] = 32'hAA;
        idle(); alu_valid = 1;
        for (int c = 0; c < 4; c++) begin
            alu_rd = ADDR_W'(20 + c);
            ld_valid = 1; ld_rd = exp_rd[c < 2 ? c : 2]; ld_data = exp_dt[c < 2 ? c : 2];
            settle();
            tests++; if (ld_ready !== (c < 2)) begin fails++; $display("FAIL full_ready%0d got %b want %b", c, ld_ready, c < 2); end
            tests++; if (stall_req !== (c == 3)) begin fails++; $display("FAIL full_stall%0d got %b want %b", c, stall_req, c == 3); end
            tick();
        end
        alu_valid = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            if (k < 2) begin
                tests++; if (ld_ready !== (k == 1)) begin fails++; $display("FAIL full_drain_ready%0d got %b want %b", k, ld_ready, k == 1); end
            end
            tick();
            if (k >= 1) ld_valid = 0;
            tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, exp_rd[k], exp_dt[k]}) begin fails++;
                $display("FAIL full_order%0d got en=%b addr=%0d data=%h want 1/%0d/%h", k, wr_en, wr_addr, wr_data, exp_rd[k], exp_dt[k]); end
        end
        tick();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL full_empty wr_en got %b want 0", wr_en); end
    endtask

    task automatic test_mid_reset();
        idle(); alu_valid = 1; alu_rd = 5'd1;
        ld_issue = 1; ld_issue_rd = 5'd11; ld_valid = 1; ld_rd = 5'd11; ld_data = 32'hB1;
        tick();
        ld_issue_rd = 5'd12; ld_rd = 5'd12; ld_data = 32'hB2;
        tick();
        idle(); q_rs1 = 5'd11;
        settle();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL mid_pre_stall got %b want 1", stall_req); end
        #1 rst_n = 0;
        model_reset();
        #1;
        tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL mid_ld_ready got %b want 0", ld_ready); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL mid_stall got %b want 0", stall_req); end
        tests++; if ({wr_en, proto_err} !== 2'b00) begin fails++; $display("FAIL mid_outputs got en=%b perr=%b want 0/0", wr_en, proto_err); end
        tick();
        tests++; if (ld_ready !== 1'b0) begin fails++; $display("FAIL mid_held_ready got %b want 0", ld_ready); end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL mid_no_write%0d wr_en got %b want 0", i, wr_en); end
        end
        for (int r = 1; r < 32; r++) begin
            q_rs1 = ADDR_W'(r);
            #1;
            tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL mid_busy%0d stall got %b want 0", r, stall_req); end
        end
        q_rs1 = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(0, 1) == 1); alu_rd = ADDR_W'($urandom); alu_data = $urandom;
            ld_valid = ($urandom_range(0, 2) != 0); ld_rd = ADDR_W'($urandom); ld_data = $urandom;
            ld_issue = ($urandom_range(0, 2) == 0); ld_issue_rd = ADDR_W'($urandom);
            q_rs1 = ADDR_W'($urandom); q_rs2 = ADDR_W'($urandom); q_rd = ADDR_W'($urandom);
            settle();
            tests++; if (ld_ready !== me_ready) begin fails++; $display("FAIL rnd%0d ld_ready got %b want %b", n, ld_ready, me_ready); end
            tests++; if (stall_req !== me_stall) begin fails++; $display("FAIL rnd%0d stall got %b want %b", n, stall_req, me_stall); end
            tick();
            tests++; if (wr_en !== me_wr) begin fails++; $display("FAIL rnd%0d wr_en got %b want %b", n, wr_en, me_wr); end
            if (me_wr) begin
                tests++; if ({wr_addr, wr_data} !== {me_addr, me_data}) begin fails++;
                    $display("FAIL rnd%0d write got addr=%0d data=%h want %0d/%h", n, wr_addr, wr_data, me_addr, me_data); end
            end
            tests++; if (proto_err !== mperr) begin fails++; $display("FAIL rnd%0d perr got %b want %b", n, proto_err, mperr); end
        end
        idle();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        test_reset();
        test_alu_only();
        test_collision();
        test_scoreboard();
        test_starvation();
        test_fifo_full();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
